// File: rtl/l1_l2_rr_arbiter_if.sv
// Bundle of every L1-side and L2-side handshake/bus signal of l1_l2_rr_arbiter.
// master: the surrounding L1 caches / L2 (or a bench); slave: the arbiter itself.
interface l1_l2_rr_arbiter_if #(
    parameter int num_L1s      = 4,
    parameter int num_L1s_log  = 2,
    parameter int addr_width   = 32,
    parameter int data_width   = 256,
    parameter int cpu_id_width = 2
);
    logic                               enable;

    logic [num_L1s-1:0]                 valid_L1_in;
    logic [num_L1s-1:0]                 rw_L1_in;
    logic [num_L1s*addr_width-1:0]      addr_L1_in;
    logic [num_L1s*data_width-1:0]      data_L1_in;
    logic [num_L1s*cpu_id_width-1:0]    id_L1_in;
    logic [num_L1s-1:0]                 L1_to_L2_full;
    logic [num_L1s-1:0]                 L1_to_L2_empty;

    logic                               valid_L2_out;
    logic                               rw_L2_out;
    logic [addr_width-1:0]              addr_L2_out;
    logic [data_width-1:0]              data_L2_out;
    logic [cpu_id_width-1:0]            id_L2_out;
    logic [num_L1s_log-1:0]             which_L1_out;
    logic                               accept_L2;

    logic                               valid_L2_in;
    logic                               rw_L2_in;
    logic [addr_width-1:0]              addr_L2_in;
    logic [data_width-1:0]              data_L2_in;
    logic [cpu_id_width-1:0]            id_L2_in;
    logic [num_L1s_log-1:0]             which_L1;
    logic                               ready_L2_in;

    logic [num_L1s-1:0]                 valid_L1_out;
    logic [num_L1s-1:0]                 rw_L1_out;
    logic [num_L1s*addr_width-1:0]      addr_L1_out;
    logic [num_L1s*data_width-1:0]      data_L1_out;
    logic [num_L1s*cpu_id_width-1:0]    id_L1_out;
    logic [num_L1s-1:0]                 accept_L1;
    logic [num_L1s-1:0]                 L2_to_L1_full;
    logic [num_L1s-1:0]                 L2_to_L1_empty;

    modport master (
        output enable,
        output valid_L1_in, rw_L1_in, addr_L1_in, data_L1_in, id_L1_in,
        input  L1_to_L2_full, L1_to_L2_empty,
        input  valid_L2_out, rw_L2_out, addr_L2_out, data_L2_out, id_L2_out, which_L1_out,
        output accept_L2,
        output valid_L2_in, rw_L2_in, addr_L2_in, data_L2_in, id_L2_in, which_L1,
        input  ready_L2_in,
        input  valid_L1_out, rw_L1_out, addr_L1_out, data_L1_out, id_L1_out,
        output accept_L1,
        input  L2_to_L1_full, L2_to_L1_empty
    );

    modport slave (
        input  enable,
        input  valid_L1_in, rw_L1_in, addr_L1_in, data_L1_in, id_L1_in,
        output L1_to_L2_full, L1_to_L2_empty,
        output valid_L2_out, rw_L2_out, addr_L2_out, data_L2_out, id_L2_out, which_L1_out,
        input  accept_L2,
        input  valid_L2_in, rw_L2_in, addr_L2_in, data_L2_in, id_L2_in, which_L1,
        output ready_L2_in,
        output valid_L1_out, rw_L1_out, addr_L1_out, data_L1_out, id_L1_out,
        input  accept_L1,
        output L2_to_L1_full, L2_to_L1_empty
    );
endinterface

// File: rtl/l1_l2_rr_arbiter.sv
// Round-robin arbiter between num_L1s private L1 caches and one shared L2.
// Each L1 owns a request FIFO; one request per accept is moved into a registered
// L2 output stage tagged with its source index. Responses are steered back by
// which_L1. Define ARB_RESP_FIFO_EN to give each L1 a response FIFO with
// backpressure; without it the response path is purely combinational.
//
//  state   | meaning
//  --------+------------------------------------------------------------
//  ST_IDLE | output stage empty, valid_L2_out = 0
//  ST_HOLD | output stage holds a request, valid_L2_out = 1 until accept

// Synchronous FIFO; writes while full and reads while empty are ignored, so a
// simultaneous push/pop on a full FIFO only pops.
module l1_l2_rr_fifo #(
    parameter int width     = 8,
    parameter int depth_log = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [width-1:0] wdata,
    output logic [width-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int depth = 1 << depth_log;
    localparam logic [depth_log:0] depth_c = (depth_log + 1)'(depth);

    logic [width-1:0]     mem_q [depth];
    logic [width-1:0]     mem_d [depth];
    logic [depth_log-1:0] wr_ptr_q, wr_ptr_d;
    logic [depth_log-1:0] rd_ptr_q, rd_ptr_d;
    logic [depth_log:0]   count_q, count_d;
    logic                 do_push, do_pop;

    assign full    = (count_q == depth_c);
    assign empty   = (count_q == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem_q[rd_ptr_q];

    // Next storage, pointers and occupancy
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Storage needs no reset: contents are only visible through the pointers
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Pointer/occupancy registers; reset discards everything queued
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
endmodule

module l1_l2_rr_arbiter #(
    parameter int num_L1s        = 4,
    parameter int num_L1s_log    = 2,
    parameter int addr_width     = 32,
    parameter int data_width     = 256,
    parameter int cpu_id_width   = 2,
    parameter int FIFO_depth_log = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    l1_l2_rr_arbiter_if.slave    bus
);
    localparam int req_w = 1 + addr_width + data_width + cpu_id_width;

    typedef enum logic {ST_IDLE, ST_HOLD} stage_t;

    logic [req_w-1:0]       req_wdata [num_L1s];
    logic [req_w-1:0]       req_head  [num_L1s];
    logic [num_L1s-1:0]     req_push, req_pop, req_full, req_empty;

    logic [num_L1s_log-1:0] gnt_idx, cand;
    logic                   gnt_found, load_en, grant_take;

    stage_t                 state_q, state_d;
    logic                   rw_out_q, rw_out_d;
    logic [addr_width-1:0]  addr_out_q, addr_out_d;
    logic [data_width-1:0]  data_out_q, data_out_d;
    logic [cpu_id_width-1:0] id_out_q, id_out_d;
    logic [num_L1s_log-1:0] which_out_q, which_out_d;
    logic [num_L1s_log-1:0] rr_ptr_q, rr_ptr_d;

    for (genvar i = 0; i < num_L1s; i++) begin : g_req
        assign req_push[i]  = bus.enable & bus.valid_L1_in[i] & ~req_full[i];
        assign req_pop[i]   = grant_take & (gnt_idx == num_L1s_log'(i));
        assign req_wdata[i] = {bus.rw_L1_in[i],
                               bus.addr_L1_in[i*addr_width +: addr_width],
                               bus.data_L1_in[i*data_width +: data_width],
                               bus.id_L1_in[i*cpu_id_width +: cpu_id_width]};
        l1_l2_rr_fifo #(.width(req_w), .depth_log(FIFO_depth_log)) u_req_fifo (
            .clk   (clk),
            .reset (reset),
            .push  (req_push[i]),
            .pop   (req_pop[i]),
            .wdata (req_wdata[i]),
            .rdata (req_head[i]),
            .full  (req_full[i]),
            .empty (req_empty[i])
        );
    end

    assign bus.L1_to_L2_full  = req_full;
    assign bus.L1_to_L2_empty = req_empty;

    // Round-robin search: first non-empty FIFO at or after rr_ptr, wrapping
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int k = 0; k < num_L1s; k++) begin
            cand = num_L1s_log'((int'(rr_ptr_q) + k) % num_L1s);
            if (!gnt_found && !req_empty[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    // The stage can be reloaded when empty or when L2 takes what it holds
    assign load_en    = bus.enable & ((state_q == ST_IDLE) | bus.accept_L2);
    assign grant_take = load_en & gnt_found;

    // Output stage next state: load a granted head, drain to idle, or hold
    always_comb begin
        state_d     = state_q;
        rw_out_d    = rw_out_q;
        addr_out_d  = addr_out_q;
        data_out_d  = data_out_q;
        id_out_d    = id_out_q;
        which_out_d = which_out_q;
        rr_ptr_d    = rr_ptr_q;
        if (load_en) begin
            if (gnt_found) begin
                state_d = ST_HOLD;
                {rw_out_d, addr_out_d, data_out_d, id_out_d} = req_head[gnt_idx];
                which_out_d = gnt_idx;
                rr_ptr_d    = (gnt_idx == num_L1s_log'(num_L1s - 1)) ? '0 : gnt_idx + 1'b1;
            end else begin
                state_d = ST_IDLE;
            end
        end
    end

    // Output stage FSM with registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            rw_out_q    <= 1'b0;
            addr_out_q  <= '0;
            data_out_q  <= '0;
            id_out_q    <= '0;
            which_out_q <= '0;
            rr_ptr_q    <= '0;
        end else begin
            state_q     <= state_d;
            rw_out_q    <= rw_out_d;
            addr_out_q  <= addr_out_d;
            data_out_q  <= data_out_d;
            id_out_q    <= id_out_d;
            which_out_q <= which_out_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign bus.valid_L2_out = (state_q == ST_HOLD);
    assign bus.rw_L2_out    = rw_out_q;
    assign bus.addr_L2_out  = addr_out_q;
    assign bus.data_L2_out  = data_out_q;
    assign bus.id_L2_out    = id_out_q;
    assign bus.which_L1_out = which_out_q;

`ifdef ARB_RESP_FIFO_EN
    logic [req_w-1:0]   rsp_wdata;
    logic [req_w-1:0]   rsp_head [num_L1s];
    logic [num_L1s-1:0] rsp_push, rsp_pop, rsp_full, rsp_empty;

    assign rsp_wdata       = {bus.rw_L2_in, bus.addr_L2_in, bus.data_L2_in, bus.id_L2_in};
    assign bus.ready_L2_in = ~rsp_full[bus.which_L1];

    for (genvar i = 0; i < num_L1s; i++) begin : g_rsp
        assign rsp_push[i] = bus.enable & bus.valid_L2_in & ~rsp_full[i]
                             & (bus.which_L1 == num_L1s_log'(i));
        assign rsp_pop[i]  = bus.enable & bus.accept_L1[i] & ~rsp_empty[i];
        l1_l2_rr_fifo #(.width(req_w), .depth_log(FIFO_depth_log)) u_rsp_fifo (
            .clk   (clk),
            .reset (reset),
            .push  (rsp_push[i]),
            .pop   (rsp_pop[i]),
            .wdata (rsp_wdata),
            .rdata (rsp_head[i]),
            .full  (rsp_full[i]),
            .empty (rsp_empty[i])
        );
        assign bus.valid_L1_out[i] = ~rsp_empty[i];
        assign {bus.rw_L1_out[i],
                bus.addr_L1_out[i*addr_width +: addr_width],
                bus.data_L1_out[i*data_width +: data_width],
                bus.id_L1_out[i*cpu_id_width +: cpu_id_width]} = rsp_head[i];
    end

    assign bus.L2_to_L1_full  = rsp_full;
    assign bus.L2_to_L1_empty = rsp_empty;
`else
    // Response fields fan out to every L1; only the addressed one sees valid
    for (genvar i = 0; i < num_L1s; i++) begin : g_rsp
        assign bus.valid_L1_out[i] = bus.enable & bus.valid_L2_in
                                     & (bus.which_L1 == num_L1s_log'(i));
        assign bus.rw_L1_out[i]    = bus.rw_L2_in;
        assign bus.addr_L1_out[i*addr_width +: addr_width]       = bus.addr_L2_in;
        assign bus.data_L1_out[i*data_width +: data_width]       = bus.data_L2_in;
        assign bus.id_L1_out[i*cpu_id_width +: cpu_id_width]     = bus.id_L2_in;
    end

    assign bus.ready_L2_in    = 1'b1;
    assign bus.L2_to_L1_full  = '0;
    assign bus.L2_to_L1_empty = '1;

    logic unused_accept_l1;
    assign unused_accept_l1 = ^bus.accept_L1;
`endif
endmodule

// File: tb/tb_l1_l2_rr_arbiter.sv
// Directed bench for l1_l2_rr_arbiter; the response-FIFO section follows ARB_RESP_FIFO_EN.
module tb_l1_l2_rr_arbiter;
    localparam int NL  = 4;
    localparam int NLL = 2;
    localparam int AW  = 32;
    localparam int DW  = 256;
    localparam int IW  = 2;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_bad = 0;

    l1_l2_rr_arbiter_if #(.num_L1s(NL), .num_L1s_log(NLL), .addr_width(AW),
                          .data_width(DW), .cpu_id_width(IW)) bus ();

    l1_l2_rr_arbiter #(.num_L1s(NL), .num_L1s_log(NLL), .addr_width(AW),
                       .data_width(DW), .cpu_id_width(IW), .FIFO_depth_log(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [31:0] a);
        bus.valid_L1_in[i]           = 1'b1;
        bus.rw_L1_in[i]              = a[0];
        bus.addr_L1_in[i*AW +: AW]   = a;
        bus.data_L1_in[i*DW +: DW]   = DW'(a) << 8;
        bus.id_L1_in[i*IW +: IW]     = a[1:0];
    endtask

    task automatic clr_req();
        bus.valid_L1_in = '0;
    endtask

    // Request fields derive from the address: data = a<<8, id = a[1:0], rw = a[0]
    task automatic check_out(input string tag, input logic [NLL-1:0] which, input logic [31:0] a);
        check({tag, " valid"}, 64'(bus.valid_L2_out), 64'd1);
        check({tag, " which"}, 64'(bus.which_L1_out), 64'(which));
        check({tag, " addr"},  64'(bus.addr_L2_out),  64'(a));
        check({tag, " data"},  bus.data_L2_out[63:0], 64'(a) << 8);
        check({tag, " id"},    64'(bus.id_L2_out),    64'(a[1:0]));
        check({tag, " rw"},    64'(bus.rw_L2_out),    64'(a[0]));
    endtask

    initial begin
        reset           = 1'b1;
        bus.enable      = 1'b1;
        bus.valid_L1_in = '0;
        bus.rw_L1_in    = '0;
        bus.addr_L1_in  = '0;
        bus.data_L1_in  = '0;
        bus.id_L1_in    = '0;
        bus.accept_L2   = 1'b0;
        bus.valid_L2_in = 1'b0;
        bus.rw_L2_in    = 1'b0;
        bus.addr_L2_in  = '0;
        bus.data_L2_in  = '0;
        bus.id_L2_in    = '0;
        bus.which_L1    = '0;
        bus.accept_L1   = '0;

        tick();
        tick();
        check("rst valid_L2_out", 64'(bus.valid_L2_out), 64'd0);
        check("rst req empty",    64'(bus.L1_to_L2_empty), 64'hF);
        check("rst req full",     64'(bus.L1_to_L2_full), 64'h0);
        check("rst which",        64'(bus.which_L1_out), 64'd0);
        check("rst addr",         64'(bus.addr_L2_out), 64'd0);
        check("rst rsp empty",    64'(bus.L2_to_L1_empty), 64'hF);
        check("rst rsp full",     64'(bus.L2_to_L1_full), 64'h0);
        check("rst valid_L1_out", 64'(bus.valid_L1_out), 64'h0);
        reset = 1'b0;

        // single request from L1 2: visible after the second edge
        set_req(2, 32'h100);
        tick();
        clr_req();
        check("t1 lat edge1 valid", 64'(bus.valid_L2_out), 64'd0);
        check("t1 fifo2 not empty", 64'(bus.L1_to_L2_empty), 64'hB);
        tick();
        check_out("t1", 2'd2, 32'h100);
        check("t1 fifos empty", 64'(bus.L1_to_L2_empty), 64'hF);
        bus.accept_L2 = 1'b1;
        tick();
        check("t1 drain valid", 64'(bus.valid_L2_out), 64'd0);
        bus.accept_L2 = 1'b0;

        // all four push together, continuous accept -> grants 0,1,2,3
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < NL; i++) set_req(i, 32'h200 + 32'(i));
        tick();
        clr_req();
        bus.accept_L2 = 1'b1;
        for (int g = 0; g < NL; g++) begin
            tick();
            check_out($sformatf("t2 g%0d", g), NLL'(g), 32'h200 + 32'(g));
        end
        tick();
        check("t2 drain valid", 64'(bus.valid_L2_out), 64'd0);
        bus.accept_L2 = 1'b0;

        // held output stays stable without accept; rr_ptr is 0 here
        set_req(1, 32'h300);
        set_req(3, 32'h303);
        tick();
        clr_req();
        tick();
        check_out("t3 load", 2'd1, 32'h300);
        for (int c = 0; c < 5; c++) begin
            tick();
            check_out($sformatf("t3 hold%0d", c), 2'd1, 32'h300);
            check($sformatf("t3 hold%0d empty", c), 64'(bus.L1_to_L2_empty), 64'h7);
        end
        bus.enable    = 1'b0;
        bus.accept_L2 = 1'b1;
        tick();
        check_out("t3 frozen", 2'd1, 32'h300);
        check("t3 frozen empty", 64'(bus.L1_to_L2_empty), 64'h7);
        bus.enable = 1'b1;
        tick();
        check_out("t3 next", 2'd3, 32'h303);
        tick();
        check("t3 drain valid", 64'(bus.valid_L2_out), 64'd0);
        bus.accept_L2 = 1'b0;

        // enable low blocks push
        bus.enable = 1'b0;
        set_req(0, 32'h350);
        tick();
        check("en0 no push", 64'(bus.L1_to_L2_empty), 64'hF);
        check("en0 no grant", 64'(bus.valid_L2_out), 64'd0);
        clr_req();
        bus.enable = 1'b1;

        // 9 pushes to L1 0 behind a blocked stage: 9th dropped
        set_req(1, 32'h4FF);
        tick();
        clr_req();
        tick();
        check_out("t4 blocker", 2'd1, 32'h4FF);
        for (int k = 0; k < 9; k++) begin
            set_req(0, 32'h400 + 32'(k));
            tick();
            if (k == 6) check("t4 full after 7", 64'(bus.L1_to_L2_full), 64'h0);
            if (k == 7) check("t4 full after 8", 64'(bus.L1_to_L2_full), 64'h1);
        end
        clr_req();
        check("t4 full after 9", 64'(bus.L1_to_L2_full), 64'h1);
        bus.accept_L2 = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            check_out($sformatf("t4 k%0d", k), 2'd0, 32'h400 + 32'(k));
            if (k == 0) check("t4 full after pop", 64'(bus.L1_to_L2_full), 64'h0);
        end
        tick();
        check("t4 9th dropped", 64'(bus.valid_L2_out), 64'd0);
        bus.accept_L2 = 1'b0;

        // reset while holding with 3 queued; rr_ptr is 1 before the reset
        for (int i = 0; i < NL; i++) set_req(i, 32'h600 + 32'(i));
        tick();
        clr_req();
        tick();
        check_out("t6 pre", 2'd1, 32'h601);
        check("t6 pre empty", 64'(bus.L1_to_L2_empty), 64'h2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t6 valid", 64'(bus.valid_L2_out), 64'd0);
        check("t6 empty", 64'(bus.L1_to_L2_empty), 64'hF);
        check("t6 which", 64'(bus.which_L1_out), 64'd0);
        check("t6 addr",  64'(bus.addr_L2_out), 64'd0);
        set_req(3, 32'h703);
        set_req(0, 32'h700);
        tick();
        clr_req();
        tick();
        check_out("t6 rr from 0", 2'd0, 32'h700);
        bus.accept_L2 = 1'b1;
        tick();
        check_out("t6 rr next", 2'd3, 32'h703);
        tick();
        check("t6 drain valid", 64'(bus.valid_L2_out), 64'd0);
        bus.accept_L2 = 1'b0;

`ifndef ARB_RESP_FIFO_EN
        // combinational response steering
        bus.valid_L2_in = 1'b1;
        bus.which_L1    = 2'd2;
        bus.rw_L2_in    = 1'b1;
        bus.addr_L2_in  = 32'h800;
        bus.data_L2_in  = DW'(32'h800) << 8;
        bus.id_L2_in    = 2'd2;
        #1;
        check("rsp valid one-hot 2", 64'(bus.valid_L1_out), 64'h4);
        check("rsp ready", 64'(bus.ready_L2_in), 64'd1);
        check("rsp addr slice2", 64'(bus.addr_L1_out[2*AW +: AW]), 64'h800);
        check("rsp addr slice0", 64'(bus.addr_L1_out[0 +: AW]), 64'h800);
        check("rsp data slice2", bus.data_L1_out[2*DW +: 64], 64'h80000);
        check("rsp id slice3", 64'(bus.id_L1_out[3*IW +: IW]), 64'd2);
        check("rsp rw", 64'(bus.rw_L1_out), 64'hF);
        bus.which_L1 = 2'd0;
        #1;
        check("rsp valid one-hot 0", 64'(bus.valid_L1_out), 64'h1);
        bus.valid_L2_in = 1'b0;
        #1;
        check("rsp valid idle", 64'(bus.valid_L1_out), 64'h0);
        check("rsp full", 64'(bus.L2_to_L1_full), 64'h0);
        check("rsp empty", 64'(bus.L2_to_L1_empty), 64'hF);
`else
        // eight responses to L1 1 with no pops fill its FIFO
        bus.valid_L2_in = 1'b1;
        bus.which_L1    = 2'd1;
        for (int k = 0; k < 8; k++) begin
            bus.addr_L2_in = 32'h900 + 32'(k);
            bus.data_L2_in = DW'(32'h900 + 32'(k)) << 8;
            bus.id_L2_in   = 2'(k);
            bus.rw_L2_in   = 1'(k);
            check($sformatf("t5 ready k%0d", k), 64'(bus.ready_L2_in), 64'd1);
            tick();
            if (k == 0) check("t5 latency", 64'(bus.valid_L1_out), 64'h2);
        end
        check("t5 full", 64'(bus.L2_to_L1_full), 64'h2);
        check("t5 ready low", 64'(bus.ready_L2_in), 64'd0);
        check("t5 empty", 64'(bus.L2_to_L1_empty), 64'hD);
        bus.addr_L2_in = 32'h9FF;
        tick();
        bus.which_L1 = 2'd0;
        #1;
        check("t5 ready other L1", 64'(bus.ready_L2_in), 64'd1);
        bus.valid_L2_in = 1'b0;
        bus.accept_L1   = 4'b0010;
        for (int k = 0; k < 8; k++) begin
            check($sformatf("t5 pop%0d valid", k), 64'(bus.valid_L1_out), 64'h2);
            check($sformatf("t5 pop%0d addr", k), 64'(bus.addr_L1_out[AW +: AW]), 64'h900 + 64'(k));
            check($sformatf("t5 pop%0d data", k), bus.data_L1_out[DW +: 64], (64'h900 + 64'(k)) << 8);
            check($sformatf("t5 pop%0d id", k), 64'(bus.id_L1_out[IW +: IW]), 64'(k % 4));
            tick();
        end
        check("t5 drained valid", 64'(bus.valid_L1_out), 64'h0);
        check("t5 drained empty", 64'(bus.L2_to_L1_empty), 64'hF);
        bus.accept_L1 = '0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
